// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver. It oversamples the asynchronous serial line using the 16x
// baud enable from the shared baud generator. It recovers start, data
// (LSB first), optional parity and stop framing. Each received word is
// presented with a one-clock valid strobe together with parity and framing
// error flags.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx_tick    in   single-cycle enable, OVERSAMPLE pulses per bit period
//   rx         in   asynchronous serial input, idles high
//   data       out  last received word, LSB = first bit on the line
//   rx_valid   out  one-clock pulse when data and flags update
//   rx_busy    out  high while a frame is in progress
//   parity_err out  parity mismatch on the last frame (0 without parity)
//   frame_err  out  stop bit sampled low on the last frame
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          ODD_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          tickCnt_q, tickCnt_d;
    logic [IW-1:0]          bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parPend_q, parPend_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   parityErr_q, parityErr_d;
    logic                   frameErr_q, frameErr_d;
    logic                   busy_q;
    logic                   rxMeta_q, rxSync_q, rxPrev_q;
    logic                   fallEdge;

    // Two-flop synchronizer plus one extra stage holding the previous
    // synchronized value for start-edge detection. All stages reset high so
    // that a reset never looks like a falling edge on an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // A held-low line never re-triggers. Only a genuine 1->0 transition does.
    assign fallEdge = rxPrev_q & ~rxSync_q;

    // State register and output registers. rx_busy is registered from the
    // next state so that it changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            parPend_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            parPend_q   <= parPend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            parityErr_q <= parityErr_d;
            frameErr_q  <= frameErr_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Next-state logic. Apart from the IDLE edge detect, nothing advances
    // without rx_tick. The start bit is checked at its middle. After that,
    // every later bit is sampled one full bit period on, which lands on the
    // middle of each bit.
    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        parPend_d   = parPend_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        parityErr_d = parityErr_q;
        frameErr_d  = frameErr_q;

        case (state_q)
            IDLE: begin
                if (fallEdge) begin
                    state_d   = START;
                    tickCnt_d = '0;
                end
            end
            START: begin
                if (rx_tick) begin
                    if (tickCnt_q == MID_START) begin
                        tickCnt_d = '0;
                        bitIdx_d  = '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_d   = rxSync_q ? IDLE : DATA;
                    end else begin
                        tickCnt_d = tickCnt_q + CW'(1);
                    end
                end
            end
            DATA: begin
                if (rx_tick) begin
                    if (tickCnt_q == FULL_BIT) begin
                        // Shift in at the MSB side. After DATA_BITS shifts,
                        // the first bit on the line sits at the LSB.
                        shift_d   = {rxSync_q, shift_q[DATA_BITS-1:1]};
                        tickCnt_d = '0;
                        if (bitIdx_q == LAST_BIT) begin
                            bitIdx_d = '0;
                            state_d  = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bitIdx_d = bitIdx_q + IW'(1);
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (rx_tick) begin
                    if (tickCnt_q == FULL_BIT) begin
                        parPend_d = (^shift_q) ^ rxSync_q ^ ODD_SENSE;
                        tickCnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        tickCnt_d = tickCnt_q + CW'(1);
                    end
                end
            end
            STOP: begin
                if (rx_tick) begin
                    if (tickCnt_q == FULL_BIT) begin
                        // Return to IDLE at mid stop bit. This lets a start bit
                        // that directly follows the stop bit be caught.
                        data_d      = shift_q;
                        parityErr_d = (PARITY_EN != 0) ? parPend_q : 1'b0;
                        frameErr_d  = ~rxSync_q;
                        valid_d     = 1'b1;
                        tickCnt_d   = '0;
                        state_d     = IDLE;
                    end else begin
                        tickCnt_d = tickCnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data       = data_q;
    assign rx_valid   = valid_q;
    assign rx_busy    = busy_q;
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Two receivers share the clock, tick and
// reset: dut0 is 8N1 and dut1 is 8E1. Each has its own serial line. Each
// frame driven onto a line pushes its expected word and flags into that
// receiver's queue. A monitor per receiver pops and compares on every
// rx_valid pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS     = 16;
    localparam int TICKDIV = 4;
    localparam int BITCLK = OS * TICKDIV;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxTick = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, busy0, busy1, pErr0, pErr1, fErr0, fErr1;

    int   testsRun = 0;
    int   testsFailed = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .rx_tick(rxTick), .rx(rx0),
        .data(data0), .rx_valid(valid0), .rx_busy(busy0),
        .parity_err(pErr0), .frame_err(fErr0)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .rx_tick(rxTick), .rx(rx1),
        .data(data1), .rx_valid(valid1), .rx_busy(busy1),
        .parity_err(pErr1), .frame_err(fErr1)
    );

    always #5 clk = ~clk;

    // One tick every TICKDIV clocks, changed on the falling edge.
    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1) % TICKDIV;
            rxTick = (div == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitors: every valid pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (valid0) begin
            if (q0.size() == 0) begin
                checkOutput("dut0 unexpected valid", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                checkOutput("dut0 data", {24'd0, data0}, {24'd0, e0.d});
                checkOutput("dut0 parity_err", {31'd0, pErr0}, {31'd0, e0.pe});
                checkOutput("dut0 frame_err", {31'd0, fErr0}, {31'd0, e0.fe});
            end
        end
    end

    always @(negedge clk) begin
        if (valid1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected valid", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                checkOutput("dut1 data", {24'd0, data1}, {24'd0, e1.d});
                checkOutput("dut1 parity_err", {31'd0, pErr1}, {31'd0, e1.pe});
                checkOutput("dut1 frame_err", {31'd0, fErr1}, {31'd0, e1.fe});
            end
        end
    end

    task automatic setLine(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic holdBits(input int n);
        repeat (n * BITCLK) @(negedge clk);
    endtask

    task automatic checkBusy(input int sel, input logic expected, input string name);
        checkOutput(name, {31'd0, (sel == 0) ? busy0 : busy1}, {31'd0, expected});
    endtask

    // Drives one whole frame and records what the receiver must report for it.
    task automatic applyStimulus(input int sel, input logic [7:0] d, input logic par,
                                 input logic stop, input bit busyCheck);
        exp_t e;
        e.d  = d;
        e.pe = (sel == 1) ? ((^d) ^ par) : 1'b0;
        e.fe = ~stop;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        setLine(sel, 1'b0);
        holdBits(1);
        for (int i = 0; i < 8; i++) begin
            setLine(sel, d[i]);
            if (busyCheck && i == 4) begin
                repeat (BITCLK / 2) @(negedge clk);
                checkBusy(sel, 1'b1, "busy mid frame");
                repeat (BITCLK / 2) @(negedge clk);
            end else begin
                holdBits(1);
            end
        end
        if (sel == 1) begin
            setLine(sel, par);
            holdBits(1);
        end
        setLine(sel, stop);
        holdBits(1);
    endtask

    initial begin
        int budget;
        logic [7:0] rd;
        logic rp, rs;
        int rsel;

        // Reset state
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset data0", {24'd0, data0}, 32'd0);
        checkOutput("reset valid0", {31'd0, valid0}, 32'd0);
        checkOutput("reset busy0", {31'd0, busy0}, 32'd0);
        checkOutput("reset perr0", {31'd0, pErr0}, 32'd0);
        checkOutput("reset ferr0", {31'd0, fErr0}, 32'd0);
        checkOutput("reset data1", {24'd0, data1}, 32'd0);
        checkOutput("reset busy1", {31'd0, busy1}, 32'd0);
        holdBits(1);

        // Plain 8N1 frame with busy tracking
        applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        holdBits(2);
        checkBusy(0, 1'b0, "busy after frame");

        // Glitch of 4 ticks: no valid, busy must drop within 8 ticks
        setLine(0, 1'b0);
        repeat (4 * TICKDIV) @(negedge clk);
        checkBusy(0, 1'b1, "glitch busy rise");
        setLine(0, 1'b1);
        budget = 8 * TICKDIV;
        while (busy0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkBusy(0, 1'b0, "glitch busy drop");
        holdBits(2);

        // Stop bit low, then a clean frame clears the flag
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        setLine(0, 1'b1);
        holdBits(1);
        applyStimulus(0, 8'h01, 1'b0, 1'b1, 1'b0);
        holdBits(1);

        // Even parity: correct bit, then wrong bit
        applyStimulus(1, 8'h03, 1'b0, 1'b1, 1'b0);
        holdBits(1);
        applyStimulus(1, 8'h03, 1'b1, 1'b1, 1'b0);
        holdBits(1);

        // Back-to-back frames with zero idle time
        applyStimulus(0, 8'h55, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 8'hAA, 1'b0, 1'b1, 1'b0);
        holdBits(2);

        // Reset during data bit 3 of 0xFF aborts the frame
        setLine(0, 1'b0);
        holdBits(1);
        setLine(0, 1'b1);
        holdBits(3);
        repeat (BITCLK / 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst data0", {24'd0, data0}, 32'd0);
        checkOutput("midrst busy0", {31'd0, busy0}, 32'd0);
        checkOutput("midrst valid0", {31'd0, valid0}, 32'd0);
        checkOutput("midrst perr1", {31'd0, pErr1}, 32'd0);
        checkOutput("midrst data1", {24'd0, data1}, 32'd0);
        holdBits(7);
        applyStimulus(0, 8'h12, 1'b0, 1'b1, 1'b0);
        holdBits(1);

        // Break: exactly one zero word with frame_err, then silence
        begin
            exp_t eb;
            eb.d = 8'h00; eb.pe = 1'b0; eb.fe = 1'b1;
            q0.push_back(eb);
        end
        setLine(0, 1'b0);
        holdBits(15);
        setLine(0, 1'b1);
        holdBits(2);

        // Randomized frames on both receivers
        for (int n = 0; n < 20; n++) begin
            rsel = int'($urandom_range(1, 0));
            rd   = 8'($urandom);
            rp   = 1'($urandom);
            rs   = ($urandom_range(7, 0) != 0);
            applyStimulus(rsel, rd, rp, rs, 1'b0);
            setLine(rsel, 1'b1);
            if (!rs || $urandom_range(1, 0) == 1)
                holdBits(1);
        end
        holdBits(2);

        checkOutput("dut0 queue drained", q0.size(), 32'd0);
        checkOutput("dut1 queue drained", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive side of the team's UART link, mirroring the transmit path.
- Oversamples the asynchronous serial line using a 16x baud enable from the shared baud generator.
- Recovers start/data/optional parity/stop framing, LSB first.
- Presents each received byte with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, rx_tick pulses per bit period; must be even and at least 8.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_tick  in  1  single-cycle enable, OVERSAMPLE pulses per bit period.
- rx  in  1  asynchronous serial input; idles high.
- data  out  DATA_BITS  last received data word, LSB = first bit on the line.
- rx_valid  out  1  one-clk pulse when data and flags update.
- rx_busy  out  1  high while a frame is in progress (state other than IDLE).
- parity_err  out  1  parity mismatch on the last frame; 0 when PARITY_EN = 0.
- frame_err  out  1  stop bit sampled low on the last frame.

Behaviour:
- Synchronizer: rx passes through 2 flops to give rx_s; all decisions use rx_s. The synchronizer resets to 1.
- Reset (synchronous, rst high on a clk edge) sets state = IDLE, tick counter = 0, bit index = 0, shift register = 0.
- Reset values of outputs: data = 0, rx_valid = 0, rx_busy = 0, parity_err = 0, frame_err = 0.
- rst mid-frame aborts the frame: no rx_valid is produced, and the next falling edge of rx_s starts a fresh frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a high-to-low transition of rx_s (previous rx_s = 1, current = 0), go to START and clear the tick counter.
  - A line that is held low does not re-trigger; a new frame needs rx_s to return high first.
- START:
  - Count rx_tick pulses.
  - On the tick where counter = OVERSAMPLE/2-1 (mid start bit):
    - if rx_s = 0, clear the counter and go to DATA;
    - if rx_s = 1, treat it as a glitch: return to IDLE, no rx_valid.
- DATA:
  - On the tick where counter = OVERSAMPLE-1, shift rx_s in at the MSB side (LSB-first reassembly), clear the counter and increment the bit index.
  - After DATA_BITS samples, go to PARITY if PARITY_EN = 1, else to STOP.
- PARITY:
  - Sample on the same mid-bit rule.
  - The error flag is set when the XOR of the data bits, the sampled parity bit and PARITY_ODD is 1.
  - Go to STOP.
- STOP:
  - Sample on the mid-bit tick.
  - In the next clk cycle: load data from the shift register, load parity_err and frame_err (frame_err = ~stop sample), pulse rx_valid high for exactly 1 clk, and return to IDLE.
  - IDLE is re-entered at mid stop bit, so a start bit that begins right after the stop bit is detected (back-to-back frames, zero idle time).
- Counting rules:
  - rx_tick with no state change only advances the counter.
  - Without rx_tick, the counter and state hold (except the IDLE edge detect, which runs every clk).
- Flags and data persist until the next rx_valid; they are not cleared by a later frame start.
- Data is delivered even when parity_err or frame_err is set.
- There is no back-pressure: a consumer that misses the rx_valid pulse loses the byte. This is not an error condition.
- rx_busy = (state != IDLE), registered with the state.
- Break condition (line held low for longer than a frame) gives one frame of data = 0 with frame_err = 1; no further frames until rx_s returns high.

Test Plan:
- Reset, then frame 0xA5 (8N1, OVERSAMPLE = 16, rx_tick every 4 clk) -> exactly one rx_valid pulse, data = 0xA5, parity_err = 0, frame_err = 0; rx_busy high from start edge to mid stop bit.
- rx low for 4 ticks, then high -> returns to IDLE, no rx_valid, rx_busy drops within 8 ticks.
- Frame 0x3C with stop bit driven low, then line high -> rx_valid, data = 0x3C, frame_err = 1; next clean frame 0x01 -> frame_err = 0.
- PARITY_EN = 1, PARITY_ODD = 0: frame 0x03 with parity bit 0 -> parity_err = 0; same frame with parity bit 1 -> parity_err = 1, data = 0x03.
- Back-to-back frames 0x55 then 0xAA with zero idle time -> two rx_valid pulses, data 0x55 then 0xAA, no errors.
- rst asserted for 1 clk during data bit 3 of 0xFF, then frame 0x12 -> no valid for the aborted frame, all outputs 0 after rst; next rx_valid gives data = 0x12.
